// File: rtl/mul_ctrl.sv
// M-extension multiply sequencer: maps MUL/MULH/MULHSU/MULHU onto a radix-2 Booth core,
// caches the last 64-bit product and returns the selected word over valid/ready.

module mul_booth (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        go,
  input  logic        sign1,
  input  logic        sign0,
  input  logic [31:0] m,
  input  logic [31:0] r,
  output logic        done,
  output logic [63:0] product_c
);
  localparam int unsigned XLEN  = 32;
  localparam int unsigned STEPS = XLEN + 2;
  localparam int unsigned AW    = XLEN + 2;

  logic [STEPS-1:0] seq;
  logic [AW-1:0]    acc;
  logic [AW-1:0]    mcand;
  logic [AW-1:0]    sum_c;
  logic [XLEN-1:0]  mplier;
  logic [XLEN-1:0]  hi_c;
  logic             qm1;
  logic             fix;

  always_comb begin
    case ({mplier[0], qm1})
      2'b01:   sum_c = acc + mcand;
      2'b10:   sum_c = acc - mcand;
      default: sum_c = acc;
    endcase
  end

  // Step 0 loads, steps 1..32 iterate, the last step presents the product.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seq    <= STEPS'(1);
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      qm1    <= 1'b0;
      fix    <= 1'b0;
    end else if (go) begin
      seq <= {seq[STEPS-2:0], seq[STEPS-1]};
      if (seq[0]) begin
        acc    <= '0;
        mplier <= r;
        qm1    <= 1'b0;
        mcand  <= {{2{sign1 & m[XLEN-1]}}, m};
        fix    <= ~sign0 & r[XLEN-1];
      end else if (!seq[STEPS-1]) begin
        acc    <= {sum_c[AW-1], sum_c[AW-1:1]};
        mplier <= {sum_c[0], mplier[XLEN-1:1]};
        qm1    <= mplier[0];
      end
    end
  end

  // Booth treats r as signed; an unsigned r with its top bit set needs m added at 2^32.
  assign hi_c      = acc[XLEN-1:0] + (fix ? mcand[XLEN-1:0] : XLEN'(0));
  assign product_c = {hi_c, mplier};
  assign done      = seq[STEPS-1];
endmodule

module mul_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic [4:0]  req_rd,
  input  logic        kill,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_rd,
  output logic        busy
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned PW   = 2 * XLEN;
  localparam logic [1:0]  OP_MUL = 2'b00;

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN, RESP} state_t;

  state_t          state, state_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
  logic [4:0]      rd_q, rd_d;
  logic            cache_valid, cache_valid_d;
  logic [XLEN-1:0] cache_rs1, cache_rs1_d, cache_rs2, cache_rs2_d;
  logic            cache_s1, cache_s1_d, cache_s0, cache_s0_d;
  logic [PW-1:0]   cache_prod, cache_prod_d;
  logic [XLEN-1:0] resp_data_d;
  logic [4:0]      resp_rd_d;
  logic            resp_valid_d, busy_d;
  logic            go, done;
  logic [PW-1:0]   product_c;
  logic            req_s1_c, req_s0_c, hit_c;

  function automatic logic [XLEN-1:0] word_sel(input logic [1:0] op, input logic [PW-1:0] p);
    return (op == OP_MUL) ? p[XLEN-1:0] : p[PW-1:XLEN];
  endfunction

  assign req_ready = (state == IDLE) & ~kill;
  assign go        = (state == BUSY) | (state == DRAIN);
  assign req_s1_c  = (req_op != 2'b11);
  assign req_s0_c  = ~req_op[1];
  // MUL only needs the low word, which is the same for every sign pair.
  assign hit_c     = cache_valid & (req_rs1 == cache_rs1) & (req_rs2 == cache_rs2) &
                     (((req_s1_c == cache_s1) & (req_s0_c == cache_s0)) | (req_op == OP_MUL));

  mul_booth u_core (
    .clk       (clk),
    .reset_n   (reset_n),
    .go        (go),
    .sign1     (op_q != 2'b11),
    .sign0     (~op_q[1]),
    .m         (rs1_q),
    .r         (rs2_q),
    .done      (done),
    .product_c (product_c)
  );

  always_comb begin
    state_d       = state;
    op_d          = op_q;
    rs1_d         = rs1_q;
    rs2_d         = rs2_q;
    rd_d          = rd_q;
    cache_valid_d = cache_valid;
    cache_rs1_d   = cache_rs1;
    cache_rs2_d   = cache_rs2;
    cache_s1_d    = cache_s1;
    cache_s0_d    = cache_s0;
    cache_prod_d  = cache_prod;
    resp_data_d   = resp_data;
    resp_rd_d     = resp_rd;
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          op_d  = req_op;
          rs1_d = req_rs1;
          rs2_d = req_rs2;
          rd_d  = req_rd;
          if (hit_c) begin
            resp_data_d = word_sel(req_op, cache_prod);
            resp_rd_d   = req_rd;
            state_d     = RESP;
          end else begin
            cache_valid_d = 1'b0;
            state_d       = BUSY;
          end
        end
      end
      BUSY: begin
        // A kill coinciding with done has nothing left to drain.
        if (kill) begin
          state_d = done ? IDLE : DRAIN;
        end else if (done) begin
          cache_valid_d = 1'b1;
          cache_rs1_d   = rs1_q;
          cache_rs2_d   = rs2_q;
          cache_s1_d    = (op_q != 2'b11);
          cache_s0_d    = ~op_q[1];
          cache_prod_d  = product_c;
          resp_data_d   = word_sel(op_q, product_c);
          resp_rd_d     = rd_q;
          state_d       = RESP;
        end
      end
      DRAIN: begin
        if (done) state_d = IDLE;
      end
      RESP: begin
        if (kill || resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    resp_valid_d = (state_d == RESP);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      op_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      cache_valid <= 1'b0;
      cache_rs1   <= '0;
      cache_rs2   <= '0;
      cache_s1    <= 1'b0;
      cache_s0    <= 1'b0;
      cache_prod  <= '0;
      resp_data   <= '0;
      resp_rd     <= '0;
      resp_valid  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_d;
      op_q        <= op_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      cache_valid <= cache_valid_d;
      cache_rs1   <= cache_rs1_d;
      cache_rs2   <= cache_rs2_d;
      cache_s1    <= cache_s1_d;
      cache_s0    <= cache_s0_d;
      cache_prod  <= cache_prod_d;
      resp_data   <= resp_data_d;
      resp_rd     <= resp_rd_d;
      resp_valid  <= resp_valid_d;
      busy        <= busy_d;
    end
  end
endmodule

// File: tb/tb_mul_ctrl.sv
// Scoreboard bench for mul_ctrl: expected words queued at accept, compared at the response handshake.

module tb_mul_ctrl;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_rs1, req_rs2;
  logic [4:0]  req_rd;
  logic        kill;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        busy;

  localparam logic [1:0] MUL = 2'b00, MULH = 2'b01, MULHSU = 2'b10, MULHU = 2'b11;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   go_cnt   = 0;

  mul_ctrl u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .req_rd     (req_rd),
    .kill       (kill),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_rd    (resp_rd),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (u_dut.go) go_cnt = go_cnt + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && resp_valid && resp_ready && !kill) begin
      if (sb.size() == 0) begin
        check("unexpected_resp", 64'(resp_valid), 64'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("resp_data", 64'(resp_data), 64'(e.data));
        check("resp_rd", 64'(resp_rd), 64'(e.rd));
        if (e.lat != 0) check("latency", 64'(cyc - e.acc), 64'(e.lat));
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, input logic [31:0] exp, input int lat,
                      input bit push, output int t);
    int n;
    exp_t e;
    n = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b; req_rd = rd;
    @(negedge clk);
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    check("req_accept", 64'(req_ready), 64'(1));
    t = cyc;
    if (push) begin
      e.rd = rd; e.data = exp; e.acc = t; e.lat = lat;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin @(negedge clk); n++; end
    if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, g0, rv_cnt, changes, n;
    logic [31:0] d0;
    logic [4:0]  r0;
    reset_n = 1'b0; req_valid = 1'b0; req_op = '0; req_rs1 = '0; req_rs2 = '0; req_rd = '0;
    kill = 1'b0; resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("rst_resp_valid", 64'(resp_valid), 64'(0));
    check("rst_resp_data", 64'(resp_data), 64'(0));
    check("rst_resp_rd", 64'(resp_rd), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_req_ready", 64'(req_ready), 64'(1));

    // Basic MUL with full miss latency and 34 go cycles.
    g0 = go_cnt;
    send(MUL, 32'h7, 32'h6, 5'd1, 32'h2A, 35, 1, t);
    wait_drain();
    check("mul_go_cycles", 64'(go_cnt - g0), 64'(34));

    // Signedness sweep; the final MUL hits the MULHSU entry.
    send(MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'h0000_0000, 35, 1, t); wait_drain();
    send(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE, 35, 1, t); wait_drain();
    send(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFF, 35, 1, t); wait_drain();
    send(MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'h0000_0001, 1, 1, t);  wait_drain();

    // MULH then MUL on the same operands served from the cache.
    send(MULH, 32'h8000_0000, 32'h2, 5'd6, 32'hFFFF_FFFF, 35, 1, t); wait_drain();
    g0 = go_cnt;
    send(MUL, 32'h8000_0000, 32'h2, 5'd7, 32'h0000_0000, 1, 1, t); wait_drain();
    check("hit_go_cycles", 64'(go_cnt - g0), 64'(0));

    // Kill during BUSY drains the core without a response.
    g0 = go_cnt;
    rv_cnt = 0;
    send(MULHU, 32'h0000_DEAD, 32'h0000_BEEF, 5'd8, 32'h0, 0, 0, t);
    while (cyc < t + 9) begin @(negedge clk); rv_cnt += int'(resp_valid); end
    @(posedge clk); #1 kill = 1'b1;
    @(posedge clk); #1 kill = 1'b0;
    while (cyc < t + 34) begin @(negedge clk); rv_cnt += int'(resp_valid); end
    check("kill_busy_at_done", 64'(busy), 64'(1));
    check("kill_req_ready_low", 64'(req_ready), 64'(0));
    @(negedge clk); rv_cnt += int'(resp_valid);
    check("kill_busy_after_done", 64'(busy), 64'(0));
    check("kill_no_resp", 64'(rv_cnt), 64'(0));
    check("kill_go_cycles", 64'(go_cnt - g0), 64'(34));
    send(MUL, 32'd3, 32'd5, 5'd9, 32'd15, 35, 1, t); wait_drain();

    // Backpressure holds the response stable; kill then drops it.
    resp_ready = 1'b0;
    send(MUL, 32'h1234, 32'h10, 5'd10, 32'h0, 0, 0, t);
    n = 0;
    while (!resp_valid && n < 100) begin @(negedge clk); n++; end
    check("bp_resp_valid", 64'(resp_valid), 64'(1));
    check("bp_latency", 64'(cyc - t), 64'(35));
    check("bp_resp_data", 64'(resp_data), 64'(32'h12340));
    check("bp_resp_rd", 64'(resp_rd), 64'(10));
    d0 = resp_data; r0 = resp_rd; changes = 0;
    repeat (20) begin
      @(negedge clk);
      if (resp_data !== d0 || resp_rd !== r0 || resp_valid !== 1'b1) changes++;
    end
    check("bp_stable", 64'(changes), 64'(0));
    @(posedge clk); #1 kill = 1'b1; resp_ready = 1'b1;
    @(posedge clk); #1 kill = 1'b0;
    @(negedge clk);
    check("resp_kill_valid", 64'(resp_valid), 64'(0));
    check("resp_kill_busy", 64'(busy), 64'(0));

    // Asynchronous reset in the middle of BUSY.
    send(MUL, 32'd9, 32'd9, 5'd11, 32'h0, 0, 0, t);
    repeat (5) @(negedge clk);
    check("pre_rst_busy", 64'(busy), 64'(1));
    @(posedge clk); #1 reset_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_resp_valid", 64'(resp_valid), 64'(0));
    check("arst_resp_data", 64'(resp_data), 64'(0));
    check("arst_resp_rd", 64'(resp_rd), 64'(0));
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    g0 = go_cnt;
    send(MUL, 32'd2, 32'd3, 5'd12, 32'd6, 35, 1, t); wait_drain();
    check("post_rst_go_cycles", 64'(go_cnt - g0), 64'(34));

    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mul_ctrl.md
# mul_ctrl

Sequencing controller for the RISC-V M-extension multiply path. It accepts MUL/MULH/MULHSU/MULHU requests from the execute stage and maps each opcode onto the signedness controls of the shared radix-2 Booth multiplier core (`mul_booth`, instantiated inside this block). It holds the core's `go` for the full iteration sequence, captures and word-selects the 64-bit product, and returns it over a valid/ready response channel. A one-entry product cache serves the common MULH→MUL pair on the same operands without re-running the core. Flushes are handled by draining the core safely.

## Interface
- No parameters; widths are fixed at XLEN=32.
- `clk` in 1: sole clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset; also drives the core's reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when `req_valid & req_ready`.
- `req_op` in 2: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (funct3[1:0]).
- `req_rs1` in 32: multiplicand operand.
- `req_rs2` in 32: multiplier operand.
- `req_rd` in 5: destination tag, returned unchanged.
- `kill` in 1: pipeline flush; discards any request in flight.
- `resp_valid` out 1: result present.
- `resp_ready` in 1: consumer accepts the result.
- `resp_data` out 32: selected product word.
- `resp_rd` out 5: tag of the result.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, BUSY, DRAIN, RESP. Reset enters IDLE with `resp_valid`=0, `resp_data`=0, `resp_rd`=0, `busy`=0, cache invalid.
- `req_ready` = IDLE & ~kill. `resp_valid` = (state==RESP).
- Core mapping: `m`=rs1, `r`=rs2. Set `sign1` when rs1 is signed and `sign0` when rs2 is signed.
  - MUL: 1/1.
  - MULH: 1/1.
  - MULHSU: 1/0.
  - MULHU: 0/0.
- Word select: MUL returns product[31:0]. All other opcodes return product[63:32].
- Accept in IDLE:
  - Latch op, rs1, rs2, rd.
  - Cache hit: cache valid, rs1 and rs2 equal the cached operands, and either the sign pair matches the cached pair or the op is MUL. On a hit, load `resp_data` from the cached product and go to RESP.
  - Miss: invalidate the cache and go to BUSY.
- BUSY: drive `go`=1 to the core every cycle. When the core asserts `done`:
  - Store the 64-bit product together with its operands and sign pair.
  - Set the cache valid.
  - Load `resp_data`/`resp_rd` and go to RESP.
- RESP: hold all response outputs stable until `resp_ready`, then go to IDLE.
- Kill:
  - IDLE: nothing is accepted.
  - BUSY: go to DRAIN.
  - RESP: drop the response and go to IDLE with `resp_valid` low the next cycle.
  - kill has priority over `resp_ready`.
- DRAIN: keep `go`=1, because the core cannot be paused or re-armed mid-sequence. When `done` arrives, discard the product, leave the cache invalid, and go to IDLE. kill while in DRAIN has no further effect.
- `go` = BUSY | DRAIN. `go` is never dropped before `done`, so the core's one-hot sequencer always returns to its load step.
- Reset mid-operation: return to IDLE asynchronously. `reset_n` must stay low across at least one rising `clk` edge so the core's sequencer also re-initialises.

## Timing
- Miss latency:
  - Request accepted in cycle T.
  - `go` is high in cycles T+1..T+34 (34 cycles; T+1 is the core's load step).
  - `done` is asserted in T+34.
  - `resp_valid` rises in T+35.
- Hit latency: accepted in T, `resp_valid` in T+1.
- Throughput: the next `req_ready` comes the cycle after the response handshake. Back-to-back hits give one result every 2 cycles.
- A kill in cycle K during BUSY makes `busy` stay high until the cycle after `done`. `req_ready` stays low throughout.
- All outputs except `req_ready` are registered.

## Test plan
- Basic MUL and latency: MUL rs1=0x0000_0007, rs2=0x0000_0006 accepted in T → `resp_valid` first high in T+35 with `resp_data`=0x0000_002A. `go` is high for exactly 34 cycles.
- Full signedness sweep on rs1=0xFFFF_FFFF, rs2=0xFFFF_FFFF (single requests):
  - MULH → 0x0000_0000.
  - MULHU → 0xFFFF_FFFE.
  - MULHSU → 0xFFFF_FFFF.
  - MUL → 0x0000_0001.
- Cache hit: MULH rs1=0x8000_0000, rs2=0x0000_0002 returns 0xFFFF_FFFF after 35 cycles. Then MUL with the same operands returns 0x0000_0000 one cycle after accept, with `go` never asserted.
- Kill in BUSY: kill 10 cycles after accepting MULHU. `resp_valid` never rises, `busy` falls in the cycle after the core's `done`. A following MUL 3×5 returns 15 with full 35-cycle latency (cache was invalidated).
- Backpressure and kill in RESP: hold `resp_ready`=0 for 20 cycles → `resp_data`/`resp_rd` stay stable. Then assert kill with `resp_ready`=1 → no handshake, and `resp_valid`=0 next cycle.
- Reset mid-op: assert `reset_n`=0 for 2 cycles during BUSY → outputs zero immediately. The next MUL 2×3 returns 6 at T+35.
